// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// operation codes presented by the control FSM and default unit latencies.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    localparam int DIV_CYCLES_DEF  = 34;
    localparam int MULT_CYCLES_DEF = 33;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cap_en, cap_div                 capture a unit result; cap_div selects divider
//   quotient_in, remainder_in       divider results (LO <- quotient, HI <- remainder)
//   product_in                      multiplier result (HI <- [63:32], LO <- [31:0])
//   mt_hi_en, mt_lo_en, mt_data     MTHI/MTLO writes, already qualified by the FSM
//   hi, lo                          registered HI/LO values
module hilo_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_en,
    input  logic        cap_div,
    input  logic [31:0] quotient_in,
    input  logic [31:0] remainder_in,
    input  logic [63:0] product_in,
    input  logic        mt_hi_en,
    input  logic        mt_lo_en,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;

    // Next-value mux: a unit capture always outranks a move-to write.
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (cap_en) begin
            if (cap_div) begin
                lo_nxt_s = quotient_in;
                hi_nxt_s = remainder_in;
            end else begin
                hi_nxt_s = product_in[63:32];
                lo_nxt_s = product_in[31:0];
            end
        end else begin
            if (mt_hi_en) begin
                hi_nxt_s = mt_data;
            end else begin
                hi_nxt_s = hi_r;
            end
            if (mt_lo_en) begin
                lo_nxt_s = mt_data;
            end else begin
                lo_nxt_s = lo_r;
            end
        end
    end

    // HI/LO storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multiply/divide units of the multicycle core.
// Accepts MULT/DIV requests, pulses the selected unit for one cycle, waits out
// the unit's fixed latency, captures the result into HI/LO and pulses done.
// A DIV with a zero divisor is rejected immediately with div_zero_exc.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, op, opnd_b            request strobe, op code, divisor (zero check)
//   mt_hi, mt_lo, mt_data        MTHI/MTLO writes, honoured only when idle
//   quotient_in, remainder_in    divider results
//   product_in                   multiplier result
//   div_op, mult_op              registered one-cycle unit start pulses
//   busy, done, div_zero_exc     status to the control FSM (all registered)
//   hi, lo                       architectural HI/LO
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opnd_b,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] mt_data,
    input  logic [31:0] quotient_in,
    input  logic [31:0] remainder_in,
    input  logic [63:0] product_in,
    output logic        div_op,
    output logic        mult_op,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // The counter is loaded in ISSUE, so N-1 plus the ISSUE and CAPTURE
    // edges lands the capture N+2 edges after acceptance.
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             op_div_r, op_div_nxt_s;
    logic             div_op_r, div_op_nxt_s;
    logic             mult_op_r, mult_op_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             exc_r, exc_nxt_s;
    logic             cap_en_s;
    logic             mt_ok_s;

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        op_div_nxt_s  = op_div_r;
        div_op_nxt_s  = 1'b0;
        mult_op_nxt_s = 1'b0;
        done_nxt_s    = 1'b0;
        exc_nxt_s     = 1'b0;
        cap_en_s      = 1'b0;
        mt_ok_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (op == OP_DIV)) begin
                    if (opnd_b == 32'd0) begin
                        exc_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = ISSUE;
                        div_op_nxt_s = 1'b1;
                        op_div_nxt_s = 1'b1;
                    end
                end else if (start && (op == OP_MULT)) begin
                    state_nxt_s   = ISSUE;
                    mult_op_nxt_s = 1'b1;
                    op_div_nxt_s  = 1'b0;
                end else begin
                    // Move-to writes only when no MULT/DIV request claims the cycle.
                    mt_ok_s = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
                cnt_nxt_s   = op_div_r ? DIV_LOAD : MULT_LOAD;
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            CAPTURE: begin
                cap_en_s    = 1'b1;
                done_nxt_s  = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // FSM state, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            op_div_r  <= 1'b0;
            div_op_r  <= 1'b0;
            mult_op_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            exc_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            op_div_r  <= op_div_nxt_s;
            div_op_r  <= div_op_nxt_s;
            mult_op_r <= mult_op_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            exc_r     <= exc_nxt_s;
        end
    end

    hilo_regs u_hilo (
        .clk          (clk),
        .reset        (reset),
        .cap_en       (cap_en_s),
        .cap_div      (op_div_r),
        .quotient_in  (quotient_in),
        .remainder_in (remainder_in),
        .product_in   (product_in),
        .mt_hi_en     (mt_hi & mt_ok_s),
        .mt_lo_en     (mt_lo & mt_ok_s),
        .mt_data      (mt_data),
        .hi           (hi),
        .lo           (lo)
    );

    assign div_op       = div_op_r;
    assign mult_op      = mult_op_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign div_zero_exc = exc_r;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequences the shared multiply and divide datapath units for the multicycle MIPS core. It accepts MULT/DIV requests from the main control FSM and issues a one-cycle start pulse to the selected unit. It counts the unit's fixed latency, captures the result into the architectural HI/LO registers and reports completion. It also detects divide-by-zero up front, holds the control FSM off through `busy`, and serves MTHI/MTLO writes.

## Interface
- `DIV_CYCLES`, default 34: edges from the divider sampling `div_op` to its quotient/remainder registers being valid.
- `MULT_CYCLES`, default 33: same measure for the multiplier.
- `CNT_W`, default 6: width of the wait counter; must hold max(DIV_CYCLES, MULT_CYCLES).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request strobe from the control FSM.
- `op`  in  2  operation: 01 MULT, 10 DIV; 00/11 are ignored.
- `opnd_b`  in  32  divisor, used for the zero check only.
- `mt_hi`, `mt_lo`  in  1 each  MTHI/MTLO write enables.
- `mt_data`  in  32  MTHI/MTLO write data.
- `quotient_in`, `remainder_in`  in  32 each  divider results.
- `product_in`  in  64  multiplier result.
- `div_op`, `mult_op`  out  1 each  unit start pulses, registered.
- `busy`  out  1  operation in flight; the control FSM stalls MFHI/MFLO/MULT/DIV.
- `done`  out  1  one-cycle pulse after HI/LO update.
- `div_zero_exc`  out  1  one-cycle divide-by-zero exception pulse.
- `hi`, `lo`  out  32 each  architectural HI/LO.

## Operation
- States:
  - IDLE: accepts requests.
  - ISSUE: unit pulse high.
  - WAIT: counting latency.
  - CAPTURE: writes HI/LO.
- IDLE, `start`=1, `op`=DIV, `opnd_b`=0:
  - No issue; stay in IDLE.
  - `div_zero_exc`=1 next cycle.
  - HI/LO unchanged.
- IDLE, `start`=1, `op`=DIV, `opnd_b`≠0: go to ISSUE with `div_op`=1. `op`=MULT does the same with `mult_op`=1.
- IDLE, `start`=1, `op`=00/11: no effect.
- ISSUE → WAIT:
  - Drop the pulse.
  - Load the counter with DIV_CYCLES−1 or MULT_CYCLES−1 for the captured op.
- WAIT: decrement each cycle; at 0 go to CAPTURE.
- CAPTURE:
  - DIV: `lo`←`quotient_in`, `hi`←`remainder_in`.
  - MULT: `hi`←`product_in[63:32]`, `lo`←`product_in[31:0]`.
  - Go to IDLE with `done`=1.
- The op type is latched at accept; `op`/`opnd_b` changes after accept are ignored.
- `busy`=1 in ISSUE, WAIT and CAPTURE.
- `start` while `busy` is dropped; no queueing.
- MTHI/MTLO:
  - Write `hi`/`lo` at the edge only in IDLE with no accepted `start` that cycle, since start has priority.
  - `mt_hi` and `mt_lo` together write both.
  - Ignored while `busy`.

## Timing
- Reset values: state IDLE, counter 0, `div_op`/`mult_op`/`busy`/`done`/`div_zero_exc`=0, `hi`=`lo`=0.
- Request accepted at edge E0.
- Unit samples its pulse at E1.
- HI/LO update at E(N+2), with N=DIV_CYCLES or MULT_CYCLES:
  - DIV default: E36.
  - MULT default: E35.
- `done` is high in the cycle after the update edge; `busy` is low in that same cycle.
- A new `start` in the `done` cycle is accepted, giving back-to-back operation.
- Zero-divisor request: `div_zero_exc` high in the cycle after E0; `busy` never rises.
- Reset mid-operation:
  - Immediate return to reset values.
  - A pending capture is abandoned; no `done`.
  - The units share `reset`.
- Pulses are exactly one cycle wide; `div_op` and `mult_op` are never both high.

## Structure
- Package `muldiv_pkg` holds:
  - state enum (IDLE/ISSUE/WAIT/CAPTURE);
  - op encodings OP_MULT=2'b01, OP_DIV=2'b10;
  - default cycle constants 34/33.
- Sub-module `hilo_regs`: the HI/LO register pair with capture/MT write-enable muxing and synchronous reset. The FSM and counter stay in the top.

## Test plan
- DIV with A=100, B=7: `div_op` pulse at E1; at E36 `lo`=14, `hi`=2; `done` one cycle; `busy` high E1–E36.
- DIV with A=−7 (0xFFFFFFF9), B=2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV with B=0 after MTHI 0xAAAA/MTLO 0x5555:
  - `div_zero_exc` pulse;
  - no `div_op`;
  - `busy` stays 0;
  - `hi`/`lo` remain 0xAAAA/0x5555.
- MULT with `product_in`=0x0000_0001_8000_0000:
  - `hi`=1, `lo`=0x80000000 at E35;
  - a DIV `start` in the `done` cycle is accepted immediately.
- `start` and `mt_hi` pulsed mid-WAIT:
  - both ignored;
  - HI/LO come only from the running op;
  - `mt_lo` with `start` in IDLE: start wins, `lo` unchanged until capture.
- `reset` asserted 10 cycles into a DIV:
  - all outputs return to 0 next edge;
  - no `done`;
  - a following MULT completes normally.
